// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: received-character bus.
// Holding register outputs plus the consumer acknowledge.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output framing_error,
    output overrun,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive framing FSM.
// Start/data/stop sequencing plus valid/ack holding register.
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic sample_strobe,
  input  logic bit_done,
  output logic bsc_enable,
  output logic busy,
  uart_rx_frame_ctrl_if.master rx_if
);

  localparam int IW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    ABORT
  } state_t;

  logic                 s1_q;
  logic                 rx_s_q;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 load;
  logic [DATA_BITS:0]   shift_cat;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      s1_q   <= serial_in;
      rx_s_q <= s1_q;
    end
  end

  // State, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign shift_cat = {rx_s_q, shift_q};

  // Frame sequencing; strobes only matter outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (sample_strobe && rx_s_q) begin
          state_d = ABORT;
        end else if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (sample_strobe) begin
          shift_d = shift_cat[DATA_BITS:1];
        end
        if (bit_done) begin
          if (idx_q == LAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_strobe) load = 1'b1;
        if (bit_done) state_d = IDLE;
      end
      ABORT: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // A new character beats a same-cycle ack; unacked loads overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shift_q;
      fe_d    = ~rx_s_q;
      valid_d = 1'b1;
      ovr_d   = rx_if.data_ack ?
                1'b0 : (ovr_q | valid_q);
    end else if (rx_if.data_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign bsc_enable          = (state_q != IDLE);
  assign busy                = (state_q != IDLE);
  assign rx_if.data_out      = data_q;
  assign rx_if.data_valid    = valid_q;
  assign rx_if.framing_error = fe_q;
  assign rx_if.overrun       = ovr_q;

  a_idx_range: assert property (
    @(posedge clk) disable iff (!rst)
    idx_q <= LAST);

  a_enable_drop: assert property (
    @(posedge clk) disable iff (!rst)
    (bsc_enable && !bit_done) |=> bsc_enable);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: random and directed frames against a
// frame-timing reference model of the receive controller.
module tb_uart_rx_frame_ctrl;
  localparam int N   = 8;
  localparam int FLEN = 16 * (N + 2);
  localparam int LOFF = 16 * (N + 1) + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       bsc_enable;
  logic       busy;
  logic [3:0] cnt;
  logic       sample_strobe;
  logic       bit_done;

  uart_rx_frame_ctrl_if #(.DATA_BITS(N)) bus ();

  uart_rx_frame_ctrl #(.DATA_BITS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .sample_strobe (sample_strobe),
    .bit_done      (bit_done),
    .bsc_enable    (bsc_enable),
    .busy          (busy),
    .rx_if         (bus)
  );

  always #5 clk = ~clk;

  // Sample counter sharing the reset, driven by bsc_enable.
  always @(posedge clk) begin
    if (!rst) cnt <= 4'd0;
    else if (bsc_enable) cnt <= cnt + 4'd1;
  end
  assign sample_strobe = (cnt == 4'd7);
  assign bit_done      = (cnt == 4'd15);

  int   cyc = 0;
  logic ack_s = 1'b0;
  logic rst_s = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ack_s <= bus.data_ack;
    rst_s <= rst;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp_v);
    end
  endtask

  // One record per frame: busy window and optional delivery edge.
  typedef struct {
    int         d;
    int         len;
    int         ld;
    logic [7:0] b;
    logic       fe;
  } rec_t;
  rec_t q[$];

  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         started = 1'b0;

  initial begin
    int         e;
    bit         ld;
    logic [7:0] lb;
    logic       lfe;
    bit         eb;
    forever begin
      @(negedge clk);
      e = cyc;
      if (!rst_s) begin
        started = 1'b1;
        q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        m_data  = 8'h00;
      end else begin
        ld  = 1'b0;
        lb  = 8'h00;
        lfe = 1'b0;
        foreach (q[i]) begin
          if (q[i].ld == e) begin
            ld  = 1'b1;
            lb  = q[i].b;
            lfe = q[i].fe;
          end
        end
        if (ld) begin
          m_ovr   = ack_s ? 1'b0 : (m_ovr | m_valid);
          m_valid = 1'b1;
          m_data  = lb;
          m_fe    = lfe;
        end else if (ack_s) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        while (q.size() > 0 &&
               q[0].d + q[0].len <= e)
          void'(q.pop_front());
      end
      eb = 1'b0;
      foreach (q[i])
        if (q[i].d <= e && e < q[i].d + q[i].len)
          eb = 1'b1;
      if (started) begin
        chk("bsc_enable", 32'(bsc_enable), 32'(eb));
        chk("busy", 32'(busy), 32'(eb));
        chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
        chk("data_out", 32'(bus.data_out), 32'(m_data));
        chk("framing_error", 32'(bus.framing_error), 32'(m_fe));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        if (!eb) chk("idle_counter", 32'(cnt), 32'd0);
      end
    end
  end

  // Literal check of one DUT output just after edge e.
  task automatic pin(input int e, input string nm,
                     input int sel, input logic [31:0] exp_v);
    logic [31:0] act;
    @(negedge clk);
    while (cyc < e) @(negedge clk);
    case (sel)
      0:       act = 32'(bus.data_valid);
      1:       act = 32'(bus.data_out);
      2:       act = 32'(bus.framing_error);
      3:       act = 32'(bus.overrun);
      4:       act = 32'(busy);
      default: act = 32'(cnt);
    endcase
    chk(nm, act, exp_v);
  endtask

  int ack_at = -1;
  bit rand_ack = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    bus.data_ack = (cyc + 1 == ack_at) ||
                   (rand_ack && $urandom_range(0, 5) == 0);
  endtask

  task automatic ack_now();
    bus.data_ack = 1'b1;
    step();
  endtask

  task automatic reset_pulse();
    int er;
    er = cyc + 1;
    fork
      pin(er, "rst_busy", 4, 0);
      pin(er, "rst_valid", 0, 0);
      pin(er, "rst_data", 1, 0);
      pin(er, "rst_cnt", 5, 0);
    join_none
    serial_in = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int gap,
                            input int rst_at);
    rec_t r;
    r.d   = cyc + 3;
    r.len = FLEN;
    r.ld  = r.d + LOFF;
    r.b   = b;
    r.fe  = ~stop;
    q.push_back(r);
    serial_in = 1'b0;
    repeat (16) step();
    for (int i = 0; i < N; i++) begin
      serial_in = b[i];
      for (int j = 0; j < 16; j++) begin
        if (i == rst_at && j == 8) begin
          reset_pulse();
          return;
        end
        step();
      end
    end
    serial_in = stop;
    repeat (16) step();
    serial_in = 1'b1;
    repeat (gap) step();
  endtask

  task automatic glitch(input int g, input int gap);
    rec_t r;
    r.d   = cyc + 3;
    r.len = 16;
    r.ld  = -1;
    r.b   = 8'h00;
    r.fe  = 1'b0;
    q.push_back(r);
    serial_in = 1'b0;
    repeat (g) step();
    serial_in = 1'b1;
    repeat (gap) step();
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    finish_run();
  end

  initial begin
    int dd;
    int ea;
    int r;
    bus.data_ack = 1'b0;
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (3) step();
    fork
      pin(cyc, "reset_valid", 0, 0);
      pin(cyc, "reset_busy", 4, 0);
      pin(cyc, "reset_ovr", 3, 0);
    join_none
    rst = 1'b1;
    repeat (4) step();

    dd = cyc + 3;
    fork
      pin(dd - 1, "start_busy_pre", 4, 0);
      pin(dd, "start_busy", 4, 1);
      pin(dd + 151, "c55_valid_pre", 0, 0);
      pin(dd + 152, "c55_valid", 0, 1);
      pin(dd + 152, "c55_data", 1, 32'h55);
      pin(dd + 152, "c55_fe", 2, 0);
      pin(dd + 159, "c55_busy_last", 4, 1);
      pin(dd + 160, "c55_busy_end", 4, 0);
      pin(dd + 160, "c55_cnt_end", 5, 0);
    join_none
    send_frame(8'h55, 1'b1, 5, -1);
    ack_now();

    dd = cyc + 3;
    fork
      pin(dd + 152, "a3_data", 1, 32'hA3);
      pin(dd + 152, "a3_valid", 0, 1);
      pin(dd + 152, "a3_fe", 2, 1);
    join_none
    send_frame(8'hA3, 1'b0, 3, -1);
    ack_now();

    dd = cyc + 3;
    fork
      pin(dd + 151, "3c_fe_hold", 2, 1);
      pin(dd + 152, "3c_fe_clear", 2, 0);
      pin(dd + 152, "3c_data", 1, 32'h3C);
    join_none
    send_frame(8'h3C, 1'b1, 2, -1);
    ack_now();

    dd = cyc + 3;
    fork
      pin(dd + 15, "abort_busy", 4, 1);
      pin(dd + 16, "abort_idle", 4, 0);
      pin(dd + 16, "abort_valid", 0, 0);
    join_none
    glitch(4, 15);
    dd = cyc + 3;
    fork
      pin(dd + 152, "0f_data", 1, 32'h0F);
      pin(dd + 152, "0f_valid", 0, 1);
    join_none
    send_frame(8'h0F, 1'b1, 3, -1);
    ack_now();

    send_frame(8'h12, 1'b1, 1, -1);
    dd = cyc + 3;
    fork
      pin(dd, "b2b_start", 4, 1);
      pin(dd + 152, "ovr_data", 1, 32'h34);
      pin(dd + 152, "ovr_flag", 3, 1);
    join_none
    send_frame(8'h34, 1'b1, 4, -1);
    ea = cyc + 1;
    fork
      pin(ea, "ack_valid", 0, 0);
      pin(ea, "ack_ovr", 3, 0);
    join_none
    ack_now();
    step();

    send_frame(8'h77, 1'b1, 2, -1);
    dd = cyc + 3;
    ack_at = dd + 152;
    fork
      pin(dd + 152, "sim_valid", 0, 1);
      pin(dd + 152, "sim_ovr", 3, 0);
      pin(dd + 152, "sim_data", 1, 32'h99);
    join_none
    send_frame(8'h99, 1'b1, 4, -1);
    ack_at = -1;
    ack_now();

    send_frame(8'hE7, 1'b1, 0, 4);
    dd = cyc + 3;
    fork
      pin(dd + 151, "c8_valid_pre", 0, 0);
      pin(dd + 152, "c8_valid", 0, 1);
      pin(dd + 152, "c8_data", 1, 32'hC8);
      pin(dd + 160, "c8_busy_end", 4, 0);
    join_none
    send_frame(8'hC8, 1'b1, 3, -1);
    ack_now();

    rand_ack = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        send_frame(8'($urandom), 1'b1, 0,
                   $urandom_range(0, N - 1));
      end else if (r < 22) begin
        r = $urandom_range(1, 7);
        glitch(r, 17 - r + $urandom_range(0, 6));
      end else begin
        send_frame(8'($urandom),
                   ($urandom_range(0, 6) != 0),
                   $urandom_range(1, 20), -1);
      end
    end
    rand_ack = 1'b0;
    repeat (20) step();
    finish_run();
  end
endmodule
